// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, opcodes and FSM state type for the MEM stage
// Purpose: bus widths, memory/register/write-back opcodes, UART addresses,
//          RAM controller states and the UART status word helper.
package mem_stage_pkg;
   localparam int DATA_W       = 16;
   localparam int PC_W         = 16;
   localparam int REG_ADDR_W   = 4;
   localparam int REG_OP_W     = 2;
   localparam int WB_DATA_OP_W = 3;
   localparam int MEM_OP_W     = 2;
   localparam int CNT_W        = 4;

   localparam logic [MEM_OP_W-1:0] MEM_OP_NOP   = 2'd0;
   localparam logic [MEM_OP_W-1:0] MEM_OP_READ  = 2'd1;
   localparam logic [MEM_OP_W-1:0] MEM_OP_WRITE = 2'd2;

   localparam logic [REG_OP_W-1:0] REG_OP_NOP = 2'd0;
   localparam logic [REG_OP_W-1:0] REG_OP_GPR = 2'd1;
   localparam logic [REG_OP_W-1:0] REG_OP_SP  = 2'd2;
   localparam logic [REG_OP_W-1:0] REG_OP_IH  = 2'd3;

   localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_NOP = 3'd0;
   localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_ALU = 3'd1;
   localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_MEM = 3'd2;
   localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_PC  = 3'd3;
   localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_IH  = 3'd4;

   localparam logic [DATA_W-1:0] UART_DATA_ADDR_DEF = 16'hBF00;
   localparam logic [DATA_W-1:0] UART_STAT_ADDR_DEF = 16'hBF01;

   typedef enum logic [1:0] {
      RAM_IDLE  = 2'd0,
      RAM_READ  = 2'd1,
      RAM_WRITE = 2'd2,
      RAM_DONE  = 2'd3
   } ram_state_e;

   // Status register layout: bit1 = rx byte available, bit0 = tx can accept.
   function automatic logic [DATA_W-1:0] uart_status(input logic rx_valid, input logic tx_ready);
      return {{(DATA_W-2){1'b0}}, rx_valid, tx_ready};
   endfunction
endpackage

// File: rtl/mem_stage_ram_ctrl.sv
// rtl/mem_stage_ram_ctrl.sv - multi-cycle RAM access FSM for the MEM stage
// Purpose: runs one RAM read or write per start, holding the registered
//          strobes for a fixed number of cycles, then spends one DONE cycle.
// Ports: start/is_write/addr/wdata request an access (sampled in IDLE only);
//        busy = access in flight (includes the accepting IDLE cycle);
//        done = DONE cycle; rdata = last read word; ram_* drive the RAM.
import mem_stage_pkg::*;

module mem_stage_ram_ctrl #(
   parameter int READ_CYCLES  = 2,
   parameter int WRITE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_write,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_en,
   output logic              ram_we
);
   ram_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              en_q, en_d;
   logic              we_q, we_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_buf_d = rd_buf_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      en_d     = en_q;
      we_d     = we_q;
      case (state_q)
         RAM_IDLE: begin
            if (start) begin
               // Address and data are captured so the RAM pins stay stable
               // for the whole access regardless of upstream glitches.
               addr_d  = addr;
               wdata_d = wdata;
               en_d    = 1'b1;
               we_d    = is_write;
               cnt_d   = is_write ? CNT_W'(WRITE_CYCLES) : CNT_W'(READ_CYCLES);
               state_d = is_write ? RAM_WRITE : RAM_READ;
            end
         end
         RAM_READ, RAM_WRITE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               en_d    = 1'b0;
               we_d    = 1'b0;
               state_d = RAM_DONE;
               if (state_q == RAM_READ) begin
                  rd_buf_d = ram_rdata;
               end
            end
         end
         default: begin
            // DONE never accepts a new start; the next op is seen in IDLE.
            state_d = RAM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RAM_IDLE;
         cnt_q    <= '0;
         rd_buf_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_buf_q <= rd_buf_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         en_q     <= en_d;
         we_q     <= we_d;
      end
   end

   assign busy      = ((state_q == RAM_IDLE) && start) || (state_q == RAM_READ) || (state_q == RAM_WRITE);
   assign done      = (state_q == RAM_DONE);
   assign rdata     = rd_buf_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_en    = en_q;
   assign ram_we    = we_q;
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: address decode, UART/RAM access, MEM/WB register
// Purpose: consumes EX/MEM (emo_*), performs RAM or serial-port accesses,
//          stalls upstream while an access is in flight and registers MEM/WB (mwo_*).
// Ports: emo_* from EX/MEM; ram_* to data RAM; uart_* to serial port;
//        mem_stall holds upstream; mwo_* feed forwarding and write-back.
import mem_stage_pkg::*;

module mem_stage #(
   parameter int                RAM_READ_CYCLES  = 2,
   parameter int                RAM_WRITE_CYCLES = 2,
   parameter logic [DATA_W-1:0] UART_DATA_ADDR   = UART_DATA_ADDR_DEF,
   parameter logic [DATA_W-1:0] UART_STAT_ADDR   = UART_STAT_ADDR_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       emo_alu_answer,
   input  logic [DATA_W-1:0]       emo_mem_wdata,
   input  logic [MEM_OP_W-1:0]     emo_mem_op,
   input  logic [PC_W-1:0]         emo_PC_wb_data,
   input  logic [DATA_W-1:0]       emo_IH_wb_data,
   input  logic [REG_ADDR_W-1:0]   emo_wb_addr,
   input  logic [REG_OP_W-1:0]     emo_reg_op,
   input  logic [WB_DATA_OP_W-1:0] emo_wb_data_op,
   input  logic [DATA_W-1:0]       ram_rdata,
   input  logic                    uart_rx_valid,
   input  logic [7:0]              uart_rx_data,
   input  logic                    uart_tx_ready,
   output logic [DATA_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_wdata,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic                    uart_rx_pop,
   output logic                    uart_tx_valid,
   output logic [7:0]              uart_tx_data,
   output logic                    mem_stall,
   output logic [DATA_W-1:0]       mwo_alu_answer,
   output logic [DATA_W-1:0]       mwo_ram_read_answer,
   output logic [DATA_W-1:0]       mwo_IH_wb_data,
   output logic [PC_W-1:0]         mwo_PC_wb_data,
   output logic [REG_ADDR_W-1:0]   mwo_wb_addr,
   output logic [REG_OP_W-1:0]     mwo_reg_op,
   output logic [WB_DATA_OP_W-1:0] mwo_wb_data_op
);
   logic is_read, is_write, is_uart_data, is_uart_stat, is_ram;
   logic ram_start, ram_busy, ram_done, tx_wait;
   logic [DATA_W-1:0] ram_rd_buf, read_answer;

   logic [DATA_W-1:0]       alu_q, alu_d, rd_ans_q, rd_ans_d, ih_q, ih_d;
   logic [PC_W-1:0]         pc_q, pc_d;
   logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [REG_OP_W-1:0]     reg_op_q, reg_op_d;
   logic [WB_DATA_OP_W-1:0] wb_op_q, wb_op_d;

   assign is_read      = (emo_mem_op == MEM_OP_READ);
   assign is_write     = (emo_mem_op == MEM_OP_WRITE);
   assign is_uart_data = (emo_alu_answer == UART_DATA_ADDR);
   assign is_uart_stat = (emo_alu_answer == UART_STAT_ADDR);
   assign is_ram       = !is_uart_data && !is_uart_stat;

   // Held low during reset so a stale op on emo_* cannot restart an access.
   assign ram_start = !rst && is_ram && (is_read || is_write);

   mem_stage_ram_ctrl #(
      .READ_CYCLES  (RAM_READ_CYCLES),
      .WRITE_CYCLES (RAM_WRITE_CYCLES)
   ) u_ram_ctrl (
      .clk       (clk),
      .rst       (rst),
      .start     (ram_start),
      .is_write  (is_write),
      .addr      (emo_alu_answer),
      .wdata     (emo_mem_wdata),
      .ram_rdata (ram_rdata),
      .busy      (ram_busy),
      .done      (ram_done),
      .rdata     (ram_rd_buf),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we)
   );

   // A UART store keeps retrying with the pipeline held until tx is ready,
   // so exactly one tx_valid pulse is produced per store.
   assign tx_wait       = !rst && is_write && is_uart_data && !uart_tx_ready;
   assign uart_tx_valid = !rst && is_write && is_uart_data && uart_tx_ready;
   assign uart_tx_data  = emo_mem_wdata[7:0];
   assign uart_rx_pop   = !rst && is_read && is_uart_data && uart_rx_valid;
   assign mem_stall     = ram_busy || tx_wait;

   always_comb begin
      read_answer = '0;
      if (is_read && is_uart_stat) begin
         read_answer = uart_status(uart_rx_valid, uart_tx_ready);
      end else if (is_read && is_uart_data && uart_rx_valid) begin
         read_answer = {{(DATA_W-8){1'b0}}, uart_rx_data};
      end else if (is_read && is_ram && ram_done) begin
         read_answer = ram_rd_buf;
      end
   end

   // While stalled MEM/WB loads a bubble so forwarding never matches a stalled op.
   always_comb begin
      alu_d     = '0;
      rd_ans_d  = '0;
      ih_d      = '0;
      pc_d      = '0;
      wb_addr_d = '0;
      reg_op_d  = REG_OP_NOP;
      wb_op_d   = WB_DATA_OP_NOP;
      if (!mem_stall) begin
         alu_d     = emo_alu_answer;
         rd_ans_d  = read_answer;
         ih_d      = emo_IH_wb_data;
         pc_d      = emo_PC_wb_data;
         wb_addr_d = emo_wb_addr;
         reg_op_d  = emo_reg_op;
         wb_op_d   = emo_wb_data_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_q     <= '0;
         rd_ans_q  <= '0;
         ih_q      <= '0;
         pc_q      <= '0;
         wb_addr_q <= '0;
         reg_op_q  <= REG_OP_NOP;
         wb_op_q   <= WB_DATA_OP_NOP;
      end else begin
         alu_q     <= alu_d;
         rd_ans_q  <= rd_ans_d;
         ih_q      <= ih_d;
         pc_q      <= pc_d;
         wb_addr_q <= wb_addr_d;
         reg_op_q  <= reg_op_d;
         wb_op_q   <= wb_op_d;
      end
   end

   assign mwo_alu_answer      = alu_q;
   assign mwo_ram_read_answer = rd_ans_q;
   assign mwo_IH_wb_data      = ih_q;
   assign mwo_PC_wb_data      = pc_q;
   assign mwo_wb_addr         = wb_addr_q;
   assign mwo_reg_op          = reg_op_q;
   assign mwo_wb_data_op      = wb_op_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
import mem_stage_pkg::*;

module tb_mem_stage;
   logic                    clk = 1'b0;
   logic                    rst;
   logic [DATA_W-1:0]       emo_alu_answer, emo_mem_wdata, emo_IH_wb_data;
   logic [MEM_OP_W-1:0]     emo_mem_op;
   logic [PC_W-1:0]         emo_PC_wb_data;
   logic [REG_ADDR_W-1:0]   emo_wb_addr;
   logic [REG_OP_W-1:0]     emo_reg_op;
   logic [WB_DATA_OP_W-1:0] emo_wb_data_op;
   logic [DATA_W-1:0]       ram_rdata;
   logic                    uart_rx_valid, uart_tx_ready;
   logic [7:0]              uart_rx_data;
   logic [DATA_W-1:0]       ram_addr, ram_wdata;
   logic                    ram_en, ram_we, uart_rx_pop, uart_tx_valid, mem_stall;
   logic [7:0]              uart_tx_data;
   logic [DATA_W-1:0]       mwo_alu_answer, mwo_ram_read_answer, mwo_IH_wb_data;
   logic [PC_W-1:0]         mwo_PC_wb_data;
   logic [REG_ADDR_W-1:0]   mwo_wb_addr;
   logic [REG_OP_W-1:0]     mwo_reg_op;
   logic [WB_DATA_OP_W-1:0] mwo_wb_data_op;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .emo_alu_answer      (emo_alu_answer),
      .emo_mem_wdata       (emo_mem_wdata),
      .emo_mem_op          (emo_mem_op),
      .emo_PC_wb_data      (emo_PC_wb_data),
      .emo_IH_wb_data      (emo_IH_wb_data),
      .emo_wb_addr         (emo_wb_addr),
      .emo_reg_op          (emo_reg_op),
      .emo_wb_data_op      (emo_wb_data_op),
      .ram_rdata           (ram_rdata),
      .uart_rx_valid       (uart_rx_valid),
      .uart_rx_data        (uart_rx_data),
      .uart_tx_ready       (uart_tx_ready),
      .ram_addr            (ram_addr),
      .ram_wdata           (ram_wdata),
      .ram_en              (ram_en),
      .ram_we              (ram_we),
      .uart_rx_pop         (uart_rx_pop),
      .uart_tx_valid       (uart_tx_valid),
      .uart_tx_data        (uart_tx_data),
      .mem_stall           (mem_stall),
      .mwo_alu_answer      (mwo_alu_answer),
      .mwo_ram_read_answer (mwo_ram_read_answer),
      .mwo_IH_wb_data      (mwo_IH_wb_data),
      .mwo_PC_wb_data      (mwo_PC_wb_data),
      .mwo_wb_addr         (mwo_wb_addr),
      .mwo_reg_op          (mwo_reg_op),
      .mwo_wb_data_op      (mwo_wb_data_op)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] rop, input logic [2:0] wop);
      emo_mem_op     = op;
      emo_alu_answer = addr;
      emo_mem_wdata  = wd;
      emo_reg_op     = rop;
      emo_wb_data_op = wop;
   endtask

   initial begin
      rst = 1'b1;
      set_op(MEM_OP_NOP, 16'h0, 16'h0, REG_OP_NOP, WB_DATA_OP_NOP);
      emo_PC_wb_data = 16'h0; emo_IH_wb_data = 16'h0; emo_wb_addr = 4'h0;
      ram_rdata = 16'h0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0; uart_tx_ready = 1'b0;
      tick; tick;
      check("reset_reg_op", 16'(mwo_reg_op), 16'(REG_OP_NOP));
      check("reset_wb_op", 16'(mwo_wb_data_op), 16'(WB_DATA_OP_NOP));
      check("reset_alu", mwo_alu_answer, 16'h0);
      check("reset_ram_en", 16'(ram_en), 16'h0);
      check("reset_stall", 16'(mem_stall), 16'h0);
      rst = 1'b0;

      // NOP ALU op passes straight through
      set_op(MEM_OP_NOP, 16'h1234, 16'h0, REG_OP_GPR, WB_DATA_OP_ALU);
      emo_wb_addr = 4'h3; emo_PC_wb_data = 16'h0102; emo_IH_wb_data = 16'h0304;
      #1 check("nop_stall", 16'(mem_stall), 16'h0);
      tick;
      check("nop_alu", mwo_alu_answer, 16'h1234);
      check("nop_wb_op", 16'(mwo_wb_data_op), 16'(WB_DATA_OP_ALU));
      check("nop_reg_op", 16'(mwo_reg_op), 16'(REG_OP_GPR));
      check("nop_wb_addr", 16'(mwo_wb_addr), 16'h3);
      check("nop_pc", mwo_PC_wb_data, 16'h0102);
      check("nop_ih", mwo_IH_wb_data, 16'h0304);
      check("nop_rd_ans", mwo_ram_read_answer, 16'h0);

      // RAM read 0x0040 -> BEEF: IDLE, READ, READ, DONE
      set_op(MEM_OP_READ, 16'h0040, 16'h0, REG_OP_GPR, WB_DATA_OP_MEM);
      emo_wb_addr = 4'h5; ram_rdata = 16'hBEEF;
      #1 check("rd_c0_stall", 16'(mem_stall), 16'h1);
      check("rd_c0_en", 16'(ram_en), 16'h0);
      tick;
      check("rd_c1_stall", 16'(mem_stall), 16'h1);
      check("rd_c1_en", 16'(ram_en), 16'h1);
      check("rd_c1_we", 16'(ram_we), 16'h0);
      check("rd_c1_addr", ram_addr, 16'h0040);
      check("rd_c1_bubble", 16'(mwo_reg_op), 16'(REG_OP_NOP));
      tick;
      check("rd_c2_stall", 16'(mem_stall), 16'h1);
      check("rd_c2_en", 16'(ram_en), 16'h1);
      check("rd_c2_addr", ram_addr, 16'h0040);
      check("rd_c2_bubble", 16'(mwo_wb_data_op), 16'(WB_DATA_OP_NOP));
      tick;
      check("rd_done_stall", 16'(mem_stall), 16'h0);
      check("rd_done_en", 16'(ram_en), 16'h0);
      check("rd_done_bubble", 16'(mwo_reg_op), 16'(REG_OP_NOP));
      tick;
      check("rd_answer", mwo_ram_read_answer, 16'hBEEF);
      check("rd_reg_op", 16'(mwo_reg_op), 16'(REG_OP_GPR));
      check("rd_wb_addr", 16'(mwo_wb_addr), 16'h5);

      // RAM write 5A5A to 0x0100
      set_op(MEM_OP_WRITE, 16'h0100, 16'h5A5A, REG_OP_NOP, WB_DATA_OP_NOP);
      ram_rdata = 16'h1111;
      #1 check("wr_c0_stall", 16'(mem_stall), 16'h1);
      check("wr_c0_we", 16'(ram_we), 16'h0);
      tick;
      check("wr_c1_we", 16'(ram_we), 16'h1);
      check("wr_c1_en", 16'(ram_en), 16'h1);
      check("wr_c1_addr", ram_addr, 16'h0100);
      check("wr_c1_data", ram_wdata, 16'h5A5A);
      check("wr_c1_stall", 16'(mem_stall), 16'h1);
      tick;
      check("wr_c2_we", 16'(ram_we), 16'h1);
      check("wr_c2_addr", ram_addr, 16'h0100);
      check("wr_c2_data", ram_wdata, 16'h5A5A);
      check("wr_c2_stall", 16'(mem_stall), 16'h1);
      tick;
      check("wr_done_we", 16'(ram_we), 16'h0);
      check("wr_done_stall", 16'(mem_stall), 16'h0);
      tick;
      check("wr_answer", mwo_ram_read_answer, 16'h0);

      // UART store 0x41 with tx_ready low for 3 cycles
      set_op(MEM_OP_WRITE, 16'hBF00, 16'h0041, REG_OP_NOP, WB_DATA_OP_NOP);
      uart_tx_ready = 1'b0;
      #1 check("tx_c0_stall", 16'(mem_stall), 16'h1);
      check("tx_c0_valid", 16'(uart_tx_valid), 16'h0);
      tick;
      check("tx_c1_stall", 16'(mem_stall), 16'h1);
      check("tx_c1_valid", 16'(uart_tx_valid), 16'h0);
      check("tx_c1_ram_en", 16'(ram_en), 16'h0);
      tick;
      check("tx_c2_stall", 16'(mem_stall), 16'h1);
      check("tx_c2_valid", 16'(uart_tx_valid), 16'h0);
      tick;
      uart_tx_ready = 1'b1;
      #1 check("tx_go_stall", 16'(mem_stall), 16'h0);
      check("tx_go_valid", 16'(uart_tx_valid), 16'h1);
      check("tx_go_data", 16'(uart_tx_data), 16'h0041);
      tick;

      // UART status read: rx_valid=1, tx_ready=0
      set_op(MEM_OP_READ, 16'hBF01, 16'h0, REG_OP_GPR, WB_DATA_OP_MEM);
      uart_rx_valid = 1'b1; uart_tx_ready = 1'b0; uart_rx_data = 8'h7E;
      #1 check("stat_stall", 16'(mem_stall), 16'h0);
      check("stat_pop", 16'(uart_rx_pop), 16'h0);
      tick;
      check("stat_answer", mwo_ram_read_answer, 16'h0002);

      // UART data read with byte available
      set_op(MEM_OP_READ, 16'hBF00, 16'h0, REG_OP_GPR, WB_DATA_OP_MEM);
      #1 check("rx_pop", 16'(uart_rx_pop), 16'h1);
      check("rx_stall", 16'(mem_stall), 16'h0);
      tick;
      check("rx_answer", mwo_ram_read_answer, 16'h007E);

      // UART data read with no byte
      uart_rx_valid = 1'b0;
      #1 check("rx_empty_pop", 16'(uart_rx_pop), 16'h0);
      tick;
      check("rx_empty_answer", mwo_ram_read_answer, 16'h0);

      // Store to status address is ignored
      set_op(MEM_OP_WRITE, 16'hBF01, 16'h00FF, REG_OP_NOP, WB_DATA_OP_NOP);
      #1 check("stat_wr_stall", 16'(mem_stall), 16'h0);
      check("stat_wr_valid", 16'(uart_tx_valid), 16'h0);
      tick;
      check("stat_wr_ram_en", 16'(ram_en), 16'h0);

      // Reset in the middle of a RAM read
      set_op(MEM_OP_READ, 16'h0040, 16'h0, REG_OP_GPR, WB_DATA_OP_MEM);
      tick;
      check("abort_pre_en", 16'(ram_en), 16'h1);
      rst = 1'b1;
      set_op(MEM_OP_NOP, 16'h0, 16'h0, REG_OP_NOP, WB_DATA_OP_NOP);
      tick;
      check("abort_ram_en", 16'(ram_en), 16'h0);
      check("abort_stall", 16'(mem_stall), 16'h0);
      check("abort_reg_op", 16'(mwo_reg_op), 16'(REG_OP_NOP));
      rst = 1'b0;
      tick;
      check("abort_idle_en", 16'(ram_en), 16'h0);
      check("abort_idle_stall", 16'(mem_stall), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
